// File: rtl/fft2d_row_feeder.sv
// fft2d_row_feeder: frame buffer and stream sequencer in front of fft_2d.
// Holds one ROWS x (2*NPT) frame (cols 0..NPT-1 real, NPT..2*NPT-1 imag) and,
// on go_i, emits a start pulse followed by ROWS*NPT/LANES back-to-back
// LANES-wide beats in the decimated order fft_2d expects.
// Build option: define FFT_FEED_PINGPONG_EN for two frame banks (load/play)
// so a new frame can be written while the previous one streams.

// One output lane: registers the real/imag sample of a beat, zero otherwise.
module fft2d_row_feeder_lane #(
    parameter int NB = 9
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_ld,
    input  logic [NB-1:0] i_re,
    input  logic [NB-1:0] i_im,
    output logic [NB-1:0] o_re,
    output logic [NB-1:0] o_im
);
    logic [NB-1:0] r_re;
    logic [NB-1:0] r_im;

    // capture the selected words on a beat, force zero between beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_re <= '0;
            r_im <= '0;
        end else if (i_ld) begin
            r_re <= i_re;
            r_im <= i_im;
        end else begin
            r_re <= '0;
            r_im <= '0;
        end
    end

    assign o_re = r_re;
    assign o_im = r_im;
endmodule

module fft2d_row_feeder #(
    parameter int NB    = 9,
    parameter int ROWS  = 32,
    parameter int NPT   = 32,
    parameter int LANES = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        wr_en_i,
    input  logic [$clog2(ROWS)-1:0]     wr_row_i,
    input  logic [$clog2(2*NPT)-1:0]    wr_col_i,
    input  logic [NB-1:0]               wr_data_i,
    input  logic                        go_i,
    output logic                        start_o,
    output logic [LANES-1:0][NB-1:0]    dr_o,
    output logic [LANES-1:0][NB-1:0]    di_o,
    output logic                        valid_o,
    output logic                        busy_o,
    output logic                        done_o
);
    localparam int BPR = NPT / LANES;       // beats per row
    localparam int CW  = $clog2(BPR);
    localparam int RW  = $clog2(ROWS);
    localparam int MCW = $clog2(2 * NPT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic              r_start;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              w_go_acc;
    logic              w_last;
    logic              w_beat;
    logic              w_wr_ok;

    logic [LANES-1:0][NB-1:0] w_re;
    logic [LANES-1:0][NB-1:0] w_im;

    // go is only honoured once the previous sequence has reached DONE
    assign w_go_acc = go_i && (r_state == S_IDLE || r_state == S_DONE);
    assign w_last   = (r_row == RW'(ROWS - 1)) && (r_col == CW'(BPR - 1));
    assign w_beat   = (r_state == S_STREAM);

`ifdef FFT_FEED_PINGPONG_EN
    logic [NB-1:0] r_mem [2][ROWS][2*NPT];
    logic          r_load_bank;
    logic          r_play_bank;

    // swap banks on every accepted go so the just-loaded frame plays
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_load_bank <= 1'b0;
            r_play_bank <= 1'b0;
        end else if (w_go_acc) begin
            r_play_bank <= r_load_bank;
            r_load_bank <= ~r_load_bank;
        end
    end

    // writes always land in the load bank, never in the bank being played
    assign w_wr_ok = wr_en_i;

    // frame storage, not cleared by reset
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) r_mem[r_load_bank][wr_row_i][wr_col_i] <= wr_data_i;
    end
`else
    logic [NB-1:0] r_mem [ROWS][2*NPT];

    // single bank: drop writes while a stream is reading the frame
    assign w_wr_ok = wr_en_i && !r_busy;

    // frame storage, not cleared by reset
    always_ff @(posedge clk_i) begin
        if (w_wr_ok) r_mem[wr_row_i][wr_col_i] <= wr_data_i;
    end
`endif

    // lane k reads column c + (LANES-1-k)*BPR, imag part NPT columns further
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [MCW-1:0] OFS = MCW'((LANES - 1 - k) * BPR);
        logic [MCW-1:0] w_cre;
        logic [MCW-1:0] w_cim;
        assign w_cre = MCW'(r_col) + OFS;
        assign w_cim = w_cre + MCW'(NPT);
`ifdef FFT_FEED_PINGPONG_EN
        assign w_re[k] = r_mem[r_play_bank][r_row][w_cre];
        assign w_im[k] = r_mem[r_play_bank][r_row][w_cim];
`else
        assign w_re[k] = r_mem[r_row][w_cre];
        assign w_im[k] = r_mem[r_row][w_cim];
`endif
        fft2d_row_feeder_lane #(.NB(NB)) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .i_ld   (w_beat),
            .i_re   (w_re[k]),
            .i_im   (w_im[k]),
            .o_re   (dr_o[k]),
            .o_im   (di_o[k])
        );
    end

    // sequencer state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // sequencer next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_go_acc) w_next = S_START;
            S_START:  w_next = S_STREAM;
            S_STREAM: if (w_last) w_next = S_DONE;
            S_DONE:   w_next = w_go_acc ? S_START : S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // beat position: col every beat, row when a row's last beat is issued
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == S_START) begin
            r_col <= '0;
            r_row <= '0;
        end else if (r_state == S_STREAM) begin
            r_col <= r_col + CW'(1);
            if (r_col == CW'(BPR - 1)) r_row <= r_row + RW'(1);
        end
    end

    // status outputs registered alongside the beat data so they line up
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_start <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_start <= (r_state == S_START);
            r_valid <= (r_state == S_STREAM);
            r_busy  <= (r_state == S_START) || (r_state == S_STREAM);
            r_done  <= (r_state == S_DONE);
        end
    end

    assign start_o = r_start;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;
endmodule

// File: tb/tb_fft2d_row_feeder.sv
// Scoreboard bench for fft2d_row_feeder: stimulus pushes expected beats from
// a frame model at go time, a negedge monitor pops and compares each beat.
module tb_fft2d_row_feeder;
    logic             clk_i;
    logic             rst_ni;
    logic             wr_en_i;
    logic [4:0]       wr_row_i;
    logic [5:0]       wr_col_i;
    logic [8:0]       wr_data_i;
    logic             go_i;
    logic             start_o;
    logic [3:0][8:0]  dr_o;
    logic [3:0][8:0]  di_o;
    logic             valid_o;
    logic             busy_o;
    logic             done_o;

    typedef struct packed {
        logic [3:0][8:0] dr;
        logic [3:0][8:0] di;
    } beat_t;

    beat_t      exp_q[$];
    logic [8:0] mdl [2][32][64];
    int         lb;
    int         checks;
    int         errors;
    int         beats;

    fft2d_row_feeder dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .wr_en_i   (wr_en_i),
        .wr_row_i  (wr_row_i),
        .wr_col_i  (wr_col_i),
        .wr_data_i (wr_data_i),
        .go_i      (go_i),
        .start_o   (start_o),
        .dr_o      (dr_o),
        .di_o      (di_o),
        .valid_o   (valid_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] pat_a(input int r, input int c);
        logic [10:0] t;
        t = {r[4:0], c[5:0]};
        return t[8:0];
    endfunction

    function automatic logic [8:0] pat_b(input int r, input int c);
        int t;
        t = r * 37 + c * 11 + 3;
        return t[8:0];
    endfunction

    task automatic mdl_wr(input int r, input int c, input logic [8:0] d, input bit busy);
`ifdef FFT_FEED_PINGPONG_EN
        mdl[lb][r][c] = d;
`else
        if (!busy) mdl[0][r][c] = d;
`endif
    endtask

    task automatic wr(input int r, input int c, input logic [8:0] d);
        wr_en_i   = 1'b1;
        wr_row_i  = 5'(r);
        wr_col_i  = 6'(c);
        wr_data_i = d;
        @(posedge clk_i); #1;
        wr_en_i   = 1'b0;
        mdl_wr(r, c, d, 1'b0);
    endtask

    task automatic load(input bit b);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 64; c++)
                wr(r, c, b ? pat_b(r, c) : pat_a(r, c));
    endtask

    // one go_i sequence; n counts edges after the go edge T0
    task automatic run_stream(input bit mids, input bit go_again, input int rst_at, input bit hand);
        int    play, st_cnt, st_at, fv, lv, d_cnt, d_at, busy_bad, zero_bad, i;
        beat_t b;
        play = 0;
`ifdef FFT_FEED_PINGPONG_EN
        play = lb;
        lb   = lb ^ 1;
`endif
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 8; c++) begin
                for (int k = 0; k < 4; k++) begin
                    b.dr[k] = mdl[play][r][c + 8 * (3 - k)];
                    b.di[k] = mdl[play][r][c + 8 * (3 - k) + 32];
                end
                exp_q.push_back(b);
            end
        beats = 0; st_cnt = 0; st_at = -1; fv = -1; lv = -1;
        d_cnt = 0; d_at = -1; busy_bad = 0; zero_bad = 0;
        go_i = 1'b1;
        @(posedge clk_i); #1;
        go_i = 1'b0;
        for (int n = 1; n <= 260; n++) begin
            go_i = go_again && (n == 50);
            i = n - 20;
            if (mids && i >= 0 && i < 128) begin
                wr_en_i   = 1'b1;
                wr_row_i  = 5'(i / 32);
                wr_col_i  = 6'(i % 32);
                wr_data_i = (i == 0) ? 9'h1FF : 9'(i * 3 + 5);
            end else begin
                wr_en_i = 1'b0;
            end
            @(posedge clk_i); #1;
            if (mids && i >= 0 && i < 128) mdl_wr(i / 32, i % 32, wr_data_i, 1'b1);
            if (start_o) begin st_cnt++; st_at = n; end
            if (valid_o) begin if (fv < 0) fv = n; lv = n; end
            if (done_o) begin d_cnt++; d_at = n; end
            if (busy_o !== (n <= 257)) busy_bad++;
            if ((n == 1 || n == 258) && (dr_o !== '0 || di_o !== '0)) zero_bad++;
            if (hand && n == 2) begin
                chk("first_dr", dr_o, {9'h000, 9'h008, 9'h010, 9'h018});
                chk("first_di", di_o, {9'h020, 9'h028, 9'h030, 9'h038});
            end
            if (hand && n == 10) chk("beat9_dr3", dr_o[3], 9'h040);
            if (hand && n == 257) begin
                chk("last_dr0", dr_o[0], 9'h1DF);
                chk("last_di0", di_o[0], 9'h1FF);
            end
            if (n == rst_at) begin
                go_i    = 1'b0;
                wr_en_i = 1'b0;
                chk("pre_rst_valid", valid_o, 1'b1);
                rst_ni = 1'b0;
                #1;
                chk("rst_outs", {start_o, valid_o, busy_o, done_o, dr_o, di_o}, '0);
                repeat (2) @(posedge clk_i);
                #1;
                chk("rst_hold_outs", {start_o, valid_o, busy_o, done_o, dr_o, di_o}, '0);
                rst_ni = 1'b1;
                exp_q.delete();
                lb = 0;
                return;
            end
        end
        wr_en_i = 1'b0;
        chk("start_count", st_cnt, 1);
        chk("start_at", st_at, 1);
        chk("valid_first", fv, 2);
        chk("valid_last", lv, 257);
        chk("done_count", d_cnt, 1);
        chk("done_at", d_at, 258);
        chk("busy_window", busy_bad, 0);
        chk("idle_zero", zero_bad, 0);
        chk("beat_count", beats, 256);
        chk("queue_left", exp_q.size(), 0);
    endtask

    // monitor: every presented beat must match the head of the scoreboard
    always @(negedge clk_i) begin
        beat_t e;
        if (rst_ni && valid_o) begin
            beats++;
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("beat_dr", dr_o, e.dr);
                chk("beat_di", di_o, e.di);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; beats = 0; lb = 0;
        wr_en_i = 1'b0; wr_row_i = '0; wr_col_i = '0; wr_data_i = '0; go_i = 1'b0;
        rst_ni = 1'b1;
        #1 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("reset_start", start_o, 1'b0);
        chk("reset_valid", valid_o, 1'b0);
        chk("reset_busy", busy_o, 1'b0);
        chk("reset_done", done_o, 1'b0);
        chk("reset_lanes", {dr_o, di_o}, '0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        load(1'b0);
        run_stream(1'b0, 1'b1, 0, 1'b1);   // frame A, extra go mid-stream
        load(1'b1);
        run_stream(1'b1, 1'b0, 0, 1'b0);   // frame B with writes during stream
        run_stream(1'b0, 1'b0, 0, 1'b0);   // shows effect (or not) of those writes
        run_stream(1'b0, 1'b0, 100, 1'b0); // reset mid-stream
        run_stream(1'b0, 1'b0, 0, 1'b0);   // fresh stream after reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
